ex_mem_stage: RTL and testbench

- EX/MEM pipeline register plus memory-access stage; sits directly downstream of the execute-stage ALU.
- Latches the ALU result and flags, then either forwards them or performs a load/store on a variable-latency data memory.
- Produces the registered MEM/WB bundle: writeback data, destination, write enable and exceptions.
- Back-pressures the upstream stages with `stall` while a memory access is outstanding.

---
 rtl/ex_mem_stage_if.sv | 47 ++++
 rtl/ex_mem_stage.sv | 189 ++++++++++++++++++
 tb/tb_ex_mem_stage.sv | 347 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ex_mem_stage_if.sv
// EX->MEM instruction handshake, data-memory port and MEM/WB bundle of ex_mem_stage.
interface ex_mem_stage_if #(
  parameter int unsigned ADDR_W = 10
);
  // EX stage presentation
  logic              in_valid;
  logic [31:0]       in_instr;
  logic [31:0]       in_result;
  logic [2:0]        in_flags;
  logic [31:0]       in_store_data;
  logic              stall;

  // data memory
  logic              dmem_req;
  logic              dmem_we;
  logic [ADDR_W-1:0] dmem_addr;
  logic [31:0]       dmem_wdata;
  logic              dmem_ack;
  logic [31:0]       dmem_rdata;

  // MEM/WB bundle
  logic              wb_valid;
  logic              wb_we;
  logic [4:0]        wb_dst;
  logic [31:0]       wb_data;
  logic              ovf_exc;
  logic              addr_exc;
  logic              bus_err;

  // Stage side: consumes EX and memory responses, produces requests and writeback.
  modport slave (
    input  in_valid, in_instr, in_result, in_flags, in_store_data,
    input  dmem_ack, dmem_rdata,
    output stall,
    output dmem_req, dmem_we, dmem_addr, dmem_wdata,
    output wb_valid, wb_we, wb_dst, wb_data, ovf_exc, addr_exc, bus_err
  );

  // Environment side: drives EX and memory, observes everything else.
  modport master (
    output in_valid, in_instr, in_result, in_flags, in_store_data,
    output dmem_ack, dmem_rdata,
    input  stall,
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
    input  wb_valid, wb_we, wb_dst, wb_data, ovf_exc, addr_exc, bus_err
  );
endinterface

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register and memory-access stage producing the registered MEM/WB bundle.
// Aligned lw/sw hold the stage in ACCESS until ack or timeout; stall back-pressures EX meanwhile.
module ex_mem_stage #(
  parameter int unsigned ADDR_W  = 10,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic          clk,
  input  logic          reset,
  ex_mem_stage_if.slave bus
);

  localparam int unsigned     CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0a;
  localparam logic [5:0] OP_SLTIU = 6'h0b;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_SLT   = 6'h2a;
  localparam logic [5:0] FN_SLTU  = 6'h2b;

  typedef enum logic {
    ST_IDLE,
    ST_ACCESS
  } state_t;

  // EX/MEM register contents; store data lives directly in dmem_wdata.
  typedef struct packed {
    logic        valid;
    logic [31:0] instr;
    logic [31:0] result;
    logic [2:0]  flags;
  } exmem_t;

  state_t           state;
  exmem_t           exm;
  logic [CNT_W-1:0] tcnt;

  logic [5:0]  in_opcode;
  logic        in_mem_access;

  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [4:0]  dst;
  logic        is_rtype;
  logic        is_lw;
  logic        is_sw;
  logic        is_mem;
  logic        misaligned;
  logic        writes;
  logic        is_slt;
  logic        is_trap;

  logic        in_access;
  logic        last_try;
  logic        advance;
  logic        complete;

  logic        nx_we;
  logic [31:0] nx_data;
  logic        nx_ovf;
  logic        nx_aexc;
  logic        nx_berr;

  logic        unused_fields;

  // Classify the instruction being presented: does capturing it start a memory access?
  always_comb begin
    in_opcode     = bus.in_instr[31:26];
    in_mem_access = bus.in_valid
                  && ((in_opcode == OP_LW) || (in_opcode == OP_SW))
                  && (bus.in_result[1:0] == 2'b00);
  end

  // Decode the registered instruction into destination, write permission and special cases.
  always_comb begin
    opcode     = exm.instr[31:26];
    funct      = exm.instr[5:0];
    is_rtype   = (opcode == OP_RTYPE);
    is_lw      = (opcode == OP_LW);
    is_sw      = (opcode == OP_SW);
    is_mem     = is_lw || is_sw;
    misaligned = (exm.result[1:0] != 2'b00);
    dst        = is_rtype ? exm.instr[15:11] : exm.instr[20:16];
    writes     = 1'b0;
    if (is_rtype) begin
      case (funct) inside
        6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07,
        [6'h20:6'h27], FN_SLT, FN_SLTU: writes = 1'b1;
        default:                        writes = 1'b0;
      endcase
    end else begin
      writes = (opcode inside {[6'h08:6'h0e]}) || is_lw;
    end
    is_slt  = is_rtype ? ((funct == FN_SLT) || (funct == FN_SLTU))
                       : ((opcode == OP_SLTI) || (opcode == OP_SLTIU));
    is_trap = is_rtype ? ((funct == FN_ADD) || (funct == FN_SUB))
                       : (opcode == OP_ADDI);
  end

  // Handshake: an access ends on ack or on its final timeout cycle, freeing EX the same cycle.
  assign in_access = (state == ST_ACCESS);
  assign last_try  = (tcnt == CNT_LAST);
  assign bus.stall = in_access && !bus.dmem_ack && !last_try;
  assign advance   = !bus.stall;
  assign complete  = exm.valid && advance;

  // Writeback bundle for the instruction leaving the register this cycle.
  always_comb begin
    nx_we   = 1'b0;
    nx_data = exm.result;
    nx_ovf  = 1'b0;
    nx_aexc = 1'b0;
    nx_berr = 1'b0;
    if (is_mem) begin
      if (misaligned) begin
        nx_aexc = 1'b1;
      end else if (!bus.dmem_ack) begin
        nx_berr = 1'b1;
      end else if (is_lw) begin
        nx_data = bus.dmem_rdata;
        nx_we   = (dst != 5'd0);
      end
    end else begin
      if (is_slt) begin
        nx_data = {31'b0, exm.flags[1]};
      end
      if (is_trap && exm.flags[0]) begin
        nx_ovf = 1'b1;
      end else begin
        nx_we = writes && (dst != 5'd0);
      end
    end
  end

  // Instruction fields with no role in this stage.
  assign unused_fields = ^{exm.instr[25:21], exm.instr[10:6], exm.flags[2]};

  // Pipeline register, access FSM, timeout counter, memory port and MEM/WB registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_IDLE;
      exm          <= '0;
      tcnt         <= '0;
      bus.dmem_req   <= 1'b0;
      bus.dmem_we    <= 1'b0;
      bus.dmem_addr  <= '0;
      bus.dmem_wdata <= '0;
      bus.wb_valid   <= 1'b0;
      bus.wb_we      <= 1'b0;
      bus.wb_dst     <= '0;
      bus.wb_data    <= '0;
      bus.ovf_exc    <= 1'b0;
      bus.addr_exc   <= 1'b0;
      bus.bus_err    <= 1'b0;
    end else begin
      if (advance) begin
        exm <= '{valid:  bus.in_valid,
                 instr:  bus.in_instr,
                 result: bus.in_result,
                 flags:  bus.in_flags};
        tcnt         <= '0;
        state        <= in_mem_access ? ST_ACCESS : ST_IDLE;
        bus.dmem_req <= in_mem_access;
        bus.dmem_we  <= in_mem_access && (in_opcode == OP_SW);
        if (in_mem_access) begin
          bus.dmem_addr  <= bus.in_result[ADDR_W+1:2];
          bus.dmem_wdata <= bus.in_store_data;
        end
      end else begin
        tcnt <= tcnt + CNT_W'(1);
      end

      bus.wb_valid <= complete;
      bus.wb_we    <= complete && nx_we;
      bus.wb_dst   <= complete ? dst : 5'd0;
      bus.wb_data  <= complete ? nx_data : 32'd0;
      bus.ovf_exc  <= complete && nx_ovf;
      bus.addr_exc <= complete && nx_aexc;
      bus.bus_err  <= complete && nx_berr;
    end
  end

endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed and randomized bench for ex_mem_stage against an instruction-level reference model.
module tb_ex_mem_stage;

  localparam int unsigned ADDR_W  = 10;
  localparam int unsigned TIMEOUT = 8;
  localparam int          NO_ACK  = 1000;

  logic clk = 1'b0;
  logic reset;
  int   n_cmp  = 0;
  int   n_fail = 0;

  ex_mem_stage_if #(.ADDR_W(ADDR_W)) bus ();

  ex_mem_stage #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [4:0]  dst;
    logic [31:0] data;
    logic        ovf;
    logic        aexc;
    logic        berr;
  } wb_exp_t;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rtype(input int rd, input logic [5:0] fn);
    return {6'h00, 5'd1, 5'd2, 5'(rd), 5'd0, fn};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input int rt);
    return {op, 5'd1, 5'(rt), 16'h0000};
  endfunction

  // Architectural outcome of one instruction; delay = cycles after req until ack.
  function automatic wb_exp_t model(input logic [31:0] instr, input logic [31:0] result,
                                    input logic [2:0] flags, input int delay,
                                    input logic [31:0] rdata);
    wb_exp_t    e;
    logic [5:0] op;
    logic [5:0] fn;
    bit         writes;
    bit         slt;
    bit         trap;
    op = instr[31:26];
    fn = instr[5:0];
    e.we   = 1'b0;
    e.dst  = (op == 6'h00) ? instr[15:11] : instr[20:16];
    e.data = result;
    e.ovf  = 1'b0;
    e.aexc = 1'b0;
    e.berr = 1'b0;
    if (op == 6'h00) begin
      writes = fn inside {6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, [6'h20:6'h27], 6'h2a, 6'h2b};
      slt    = fn inside {6'h2a, 6'h2b};
      trap   = fn inside {6'h20, 6'h22};
    end else begin
      writes = op inside {[6'h08:6'h0e], 6'h23};
      slt    = op inside {6'h0a, 6'h0b};
      trap   = (op == 6'h08);
    end
    if (op == 6'h23 || op == 6'h2b) begin
      if (result[1:0] != 2'b00) e.aexc = 1'b1;
      else if (delay >= int'(TIMEOUT)) e.berr = 1'b1;
      else if (op == 6'h23) begin
        e.data = rdata;
        e.we   = (e.dst != 5'd0);
      end
    end else begin
      if (slt) e.data = {31'b0, flags[1]};
      e.ovf = trap && flags[0];
      e.we  = writes && !e.ovf && (e.dst != 5'd0);
    end
    return e;
  endfunction

  task automatic chk_wb(input string tag, input wb_exp_t e);
    chk({tag, ".wb_valid"}, 32'(bus.wb_valid), 32'd1);
    chk({tag, ".wb_we"},    32'(bus.wb_we),    32'(e.we));
    if (e.we) begin
      chk({tag, ".wb_dst"},  32'(bus.wb_dst), 32'(e.dst));
      chk({tag, ".wb_data"}, bus.wb_data,     e.data);
    end
    chk({tag, ".ovf_exc"},  32'(bus.ovf_exc),  32'(e.ovf));
    chk({tag, ".addr_exc"}, 32'(bus.addr_exc), 32'(e.aexc));
    chk({tag, ".bus_err"},  32'(bus.bus_err),  32'(e.berr));
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, ".q_wb_valid"}, 32'(bus.wb_valid), 32'd0);
    chk({tag, ".q_exc"}, 32'({bus.ovf_exc, bus.addr_exc, bus.bus_err}), 32'd0);
    chk({tag, ".q_req"}, 32'(bus.dmem_req), 32'd0);
    chk({tag, ".q_stall"}, 32'(bus.stall), 32'd0);
  endtask

  // Issue one instruction into an empty stage and follow it to writeback. Entered at negedge.
  task automatic run_op(input string tag, input logic [31:0] instr, input logic [31:0] result,
                        input logic [2:0] flags, input logic [31:0] sdata,
                        input int delay, input logic [31:0] rdata);
    wb_exp_t    e;
    logic [5:0] op;
    bit         access;
    e      = model(instr, result, flags, delay, rdata);
    op     = instr[31:26];
    access = (op == 6'h23 || op == 6'h2b) && (result[1:0] == 2'b00);
    bus.in_valid      = 1'b1;
    bus.in_instr      = instr;
    bus.in_result     = result;
    bus.in_flags      = flags;
    bus.in_store_data = sdata;
    bus.dmem_ack      = 1'b0;
    #1;
    chk({tag, ".stall_in"}, 32'(bus.stall), 32'd0);
    @(posedge clk);
    @(negedge clk);
    bus.in_valid      = 1'b0;
    bus.in_instr      = $urandom;
    bus.in_result     = $urandom;
    bus.in_store_data = $urandom;
    if (access) begin
      for (int k = 0; k < int'(TIMEOUT); k++) begin
        bus.dmem_ack   = (k == delay);
        bus.dmem_rdata = (k == delay) ? rdata : $urandom;
        #1;
        chk({tag, ".req"}, 32'(bus.dmem_req), 32'd1);
        if (k == 0) begin
          chk({tag, ".dmem_we"},   32'(bus.dmem_we),   32'(op == 6'h2b));
          chk({tag, ".dmem_addr"}, 32'(bus.dmem_addr), 32'(result[ADDR_W+1:2]));
          if (op == 6'h2b) chk({tag, ".dmem_wdata"}, bus.dmem_wdata, sdata);
        end
        chk({tag, ".stall"}, 32'(bus.stall),
            32'((k != delay) && (k != int'(TIMEOUT) - 1)));
        chk({tag, ".wb_wait"}, 32'(bus.wb_valid), 32'd0);
        if (k == delay || k == int'(TIMEOUT) - 1) break;
        @(posedge clk);
        @(negedge clk);
      end
      @(posedge clk);
      #1;
      bus.dmem_ack = 1'b0;
      @(negedge clk);
    end else begin
      chk({tag, ".no_req"}, 32'(bus.dmem_req), 32'd0);
      chk({tag, ".wb_early"}, 32'(bus.wb_valid), 32'd0);
      @(posedge clk);
      @(negedge clk);
    end
    chk_wb(tag, e);
    chk({tag, ".req_after"}, 32'(bus.dmem_req), 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk_quiet(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within the time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset             = 1'b1;
    bus.in_valid      = 1'b0;
    bus.in_instr      = '0;
    bus.in_result     = '0;
    bus.in_flags      = '0;
    bus.in_store_data = '0;
    bus.dmem_ack      = 1'b0;
    bus.dmem_rdata    = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset.wb_valid", 32'(bus.wb_valid), 32'd0);
    chk("reset.wb_we",    32'(bus.wb_we),    32'd0);
    chk("reset.wb_dst",   32'(bus.wb_dst),   32'd0);
    chk("reset.wb_data",  bus.wb_data,       32'd0);
    chk("reset.exc", 32'({bus.ovf_exc, bus.addr_exc, bus.bus_err}), 32'd0);
    chk("reset.dmem", 32'({bus.dmem_req, bus.dmem_we}), 32'd0);
    chk("reset.dmem_addr",  32'(bus.dmem_addr), 32'd0);
    chk("reset.dmem_wdata", bus.dmem_wdata, 32'd0);
    chk("reset.stall", 32'(bus.stall), 32'd0);
    reset = 1'b0;

    // ALU ops, slt flag selection, overflow trapping
    run_op("addu",      rtype(3, 6'h21), 32'h0000_0005, 3'b000, 32'h0, 0, 32'h0);
    run_op("slt_lt",    rtype(4, 6'h2a), 32'hFFFF_FFFE, 3'b010, 32'h0, 0, 32'h0);
    run_op("slt_ge",    rtype(4, 6'h2a), 32'hFFFF_FFFE, 3'b000, 32'h0, 0, 32'h0);
    run_op("add_ovf",   rtype(5, 6'h20), 32'h8000_0000, 3'b001, 32'h0, 0, 32'h0);
    run_op("addu_ovf",  rtype(5, 6'h21), 32'h8000_0000, 3'b001, 32'h0, 0, 32'h0);
    run_op("addi_ovf",  itype(6'h08, 6), 32'h7FFF_FFFF, 3'b001, 32'h0, 0, 32'h0);
    run_op("sltiu",     itype(6'h0b, 6), 32'h1234_5678, 3'b010, 32'h0, 0, 32'h0);
    run_op("beq",       itype(6'h04, 9), 32'h0000_0000, 3'b100, 32'h0, 0, 32'h0);
    run_op("addu_r0",   rtype(0, 6'h21), 32'h0000_0077, 3'b000, 32'h0, 0, 32'h0);

    // Stores: misaligned, aligned with immediate ack
    run_op("sw_mis",    itype(6'h2b, 3), 32'h0000_0012, 3'b000, 32'h1111_2222, 0, 32'h0);
    run_op("sw_ok",     itype(6'h2b, 3), 32'h0000_0020, 3'b000, 32'hCAFE_0001, 0, 32'h0);
    run_op("lw_mis",    itype(6'h23, 7), 32'h0000_0011, 3'b000, 32'h0, 0, 32'h0);
    run_op("lw_to",     itype(6'h23, 7), 32'h0000_0100, 3'b000, 32'h0, NO_ACK, 32'h0);
    run_op("lw_last",   itype(6'h23, 7), 32'h0000_0104, 3'b000, 32'h0, int'(TIMEOUT) - 1, 32'h5A5A_A5A5);

    // lw with ack three cycles after req, addu captured on the ack edge
    bus.in_valid  = 1'b1;
    bus.in_instr  = itype(6'h23, 7);
    bus.in_result = 32'h0000_0010;
    bus.in_flags  = 3'b000;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("lw3.req", 32'(bus.dmem_req), 32'd1);
      chk("lw3.stall", 32'(bus.stall), 32'd1);
      if (k == 0) begin
        chk("lw3.addr", 32'(bus.dmem_addr), 32'd4);
        chk("lw3.we", 32'(bus.dmem_we), 32'd0);
      end
      @(posedge clk);
      @(negedge clk);
    end
    bus.dmem_ack   = 1'b1;
    bus.dmem_rdata = 32'hDEAD_BEEF;
    bus.in_valid   = 1'b1;
    bus.in_instr   = rtype(3, 6'h21);
    bus.in_result  = 32'h0000_0005;
    #1;
    chk("lw3.stall_ack", 32'(bus.stall), 32'd0);
    @(posedge clk);
    #1;
    bus.dmem_ack = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("lw3.wb_valid", 32'(bus.wb_valid), 32'd1);
    chk("lw3.wb_we", 32'(bus.wb_we), 32'd1);
    chk("lw3.wb_dst", 32'(bus.wb_dst), 32'd7);
    chk("lw3.wb_data", bus.wb_data, 32'hDEAD_BEEF);
    chk("lw3.req_off", 32'(bus.dmem_req), 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk("b2b_addu.wb_valid", 32'(bus.wb_valid), 32'd1);
    chk("b2b_addu.wb_dst", 32'(bus.wb_dst), 32'd3);
    chk("b2b_addu.wb_data", bus.wb_data, 32'd5);
    @(posedge clk);
    @(negedge clk);
    chk_quiet("b2b_addu");

    // Two loads back to back with combinational ack: no bubble between them
    bus.in_valid  = 1'b1;
    bus.in_instr  = itype(6'h23, 8);
    bus.in_result = 32'h0000_0040;
    @(posedge clk);
    @(negedge clk);
    bus.in_instr   = itype(6'h23, 9);
    bus.in_result  = 32'h0000_0044;
    bus.dmem_ack   = 1'b1;
    bus.dmem_rdata = 32'h1111_1111;
    #1;
    chk("ll.stall0", 32'(bus.stall), 32'd0);
    chk("ll.addr0", 32'(bus.dmem_addr), 32'h10);
    @(posedge clk);
    #1;
    bus.in_valid   = 1'b0;
    bus.dmem_rdata = 32'h2222_2222;
    @(negedge clk);
    chk("ll.wb0_dst", 32'(bus.wb_dst), 32'd8);
    chk("ll.wb0_data", bus.wb_data, 32'h1111_1111);
    chk("ll.req1", 32'(bus.dmem_req), 32'd1);
    chk("ll.addr1", 32'(bus.dmem_addr), 32'h11);
    @(posedge clk);
    #1;
    bus.dmem_ack = 1'b0;
    @(negedge clk);
    chk("ll.wb1_valid", 32'(bus.wb_valid), 32'd1);
    chk("ll.wb1_dst", 32'(bus.wb_dst), 32'd9);
    chk("ll.wb1_data", bus.wb_data, 32'h2222_2222);
    chk("ll.req_off", 32'(bus.dmem_req), 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk_quiet("ll");

    // Reset during the third ACCESS cycle aborts the load with no writeback
    bus.in_valid  = 1'b1;
    bus.in_instr  = itype(6'h23, 10);
    bus.in_result = 32'h0000_0080;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      chk("rst_mid.req", 32'(bus.dmem_req), 32'd1);
      @(posedge clk);
      @(negedge clk);
    end
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("rst_mid.req", 32'(bus.dmem_req), 32'd0);
    chk("rst_mid.wb_valid", 32'(bus.wb_valid), 32'd0);
    chk("rst_mid.wb_we", 32'(bus.wb_we), 32'd0);
    chk("rst_mid.wb_dst", 32'(bus.wb_dst), 32'd0);
    chk("rst_mid.wb_data", bus.wb_data, 32'd0);
    chk("rst_mid.exc", 32'({bus.ovf_exc, bus.addr_exc, bus.bus_err}), 32'd0);
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk_quiet("rst_after");

    // Randomized instruction mix against the model
    for (int i = 0; i < 40; i++) begin
      logic [31:0] ins;
      logic [31:0] res;
      logic [5:0]  op;
      int          d;
      ins = $urandom;
      case ($urandom_range(0, 4))
        0: op = 6'h00;
        1: op = 6'h23;
        2: op = 6'h2b;
        3: begin
          op = 6'h00;
          ins[5:0] = 6'($urandom_range(32, 43));
        end
        default: op = 6'($urandom);
      endcase
      ins[31:26] = op;
      res = $urandom;
      if ($urandom_range(0, 2) != 0) res[1:0] = 2'b00;
      d = $urandom_range(0, 10);
      run_op("rand", ins, res, 3'($urandom), $urandom, d, $urandom);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
